// File: rtl/pid_input_arbiter.sv
// Round-robin input arbiter in front of the single-issue PID pipeline.
// Each source has a one-deep holding register. Held samples are issued one at a
// time as (dv, src, data) beats, spaced at least ISSUE_GAP cycles apart.
module pid_input_arbiter #(
    parameter int N_SRC     = 8,
    parameter int W_SRC     = 5,
    parameter int W_DATA    = 18,
    parameter int ISSUE_GAP = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [N_SRC-1:0]          dv_in,
    input  logic [N_SRC*W_DATA-1:0]   data_in,
    input  logic                      ovf_clr,
    output logic                      dv_out,
    output logic [W_SRC-1:0]          src_out,
    output logic signed [W_DATA-1:0]  data_out,
    output logic [N_SRC-1:0]          pending_out,
    output logic [N_SRC-1:0]          ovf_out
);

    localparam int W_IDX = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int W_GAP = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [W_GAP-1:0] GAP_LOAD = W_GAP'(ISSUE_GAP - 1);
    localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(N_SRC - 1);

    logic [W_DATA-1:0] hold_reg [N_SRC];
    logic [N_SRC-1:0]  pend_reg;
    logic [N_SRC-1:0]  ovf_reg;
    logic [W_IDX-1:0]  rr_ptr_reg;
    logic [W_IDX-1:0]  rr_ptr_next;
    logic [W_GAP-1:0]  gap_cnt_reg;

    logic              grant_found;
    logic [W_IDX-1:0]  grant_idx;
    logic              grant_fire;
    logic [W_IDX:0]    cand;

    // Rotating priority scan: first pending source at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 0; off < N_SRC; off++) begin
            cand = {1'b0, rr_ptr_reg} + (W_IDX+1)'(off);
            if (cand >= (W_IDX+1)'(N_SRC)) begin
                cand = cand - (W_IDX+1)'(N_SRC);
            end
            if (!grant_found && pend_reg[cand[W_IDX-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[W_IDX-1:0];
            end
        end
    end

    // A grant happens only when the issue gap has elapsed.
    assign grant_fire  = grant_found && (gap_cnt_reg == '0);
    assign rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            logic granted_here;
            logic ovf_event;

            assign granted_here = grant_fire && (grant_idx == W_IDX'(gi));
            // Overwriting a held sample that is not leaving this cycle loses it.
            assign ovf_event    = dv_in[gi] && pend_reg[gi] && !granted_here;

            // Holding register: a new strobe always loads; the grant reads the old value.
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    hold_reg[gi] <= '0;
                end else if (dv_in[gi]) begin
                    hold_reg[gi] <= data_in[gi*W_DATA +: W_DATA];
                end
            end

            // Pending flag: set by arrival (wins over grant), cleared by grant.
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    pend_reg[gi] <= 1'b0;
                end else if (dv_in[gi]) begin
                    pend_reg[gi] <= 1'b1;
                end else if (granted_here) begin
                    pend_reg[gi] <= 1'b0;
                end
            end

            // Sticky overflow flag: a same-cycle overflow beats the clear.
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    ovf_reg[gi] <= 1'b0;
                end else if (ovf_event) begin
                    ovf_reg[gi] <= 1'b1;
                end else if (ovf_clr) begin
                    ovf_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Round-robin pointer advances past the granted source.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr_reg <= '0;
        end else if (grant_fire) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Issue gap counter: reloaded on grant, counts down to zero otherwise.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            gap_cnt_reg <= '0;
        end else if (grant_fire) begin
            gap_cnt_reg <= GAP_LOAD;
        end else if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
        end
    end

    // Registered issue beat; src/data keep their last values between beats.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dv_out   <= 1'b0;
            src_out  <= '0;
            data_out <= '0;
        end else begin
            dv_out <= grant_fire;
            if (grant_fire) begin
                src_out  <= W_SRC'(grant_idx);
                data_out <= hold_reg[grant_idx];
            end
        end
    end

    assign pending_out = pend_reg;
    assign ovf_out     = ovf_reg;

endmodule

// File: tb/tb_pid_input_arbiter.sv
// Directed bench for pid_input_arbiter: one instance with back-to-back issue,
// one with a 4-cycle issue gap.
module tb_pid_input_arbiter;

    localparam int N  = 8;
    localparam int WS = 5;
    localparam int WD = 18;

    logic              clk;
    logic              rst;

    logic [N-1:0]      dv1;
    logic [N*WD-1:0]   data1;
    logic              clr1;
    logic              dvo1;
    logic [WS-1:0]     src1;
    logic [WD-1:0]     dat1;
    logic [N-1:0]      pend1;
    logic [N-1:0]      ovf1;

    logic [N-1:0]      dv4;
    logic [N*WD-1:0]   data4;
    logic              clr4;
    logic              dvo4;
    logic [WS-1:0]     src4;
    logic [WD-1:0]     dat4;
    logic [N-1:0]      pend4;
    logic [N-1:0]      ovf4;

    int errors = 0;
    int checks = 0;

    pid_input_arbiter #(.N_SRC(N), .W_SRC(WS), .W_DATA(WD), .ISSUE_GAP(1)) dut1 (
        .clk_in(clk), .rst_in(rst), .dv_in(dv1), .data_in(data1), .ovf_clr(clr1),
        .dv_out(dvo1), .src_out(src1), .data_out(dat1),
        .pending_out(pend1), .ovf_out(ovf1)
    );

    pid_input_arbiter #(.N_SRC(N), .W_SRC(WS), .W_DATA(WD), .ISSUE_GAP(4)) dut4 (
        .clk_in(clk), .rst_in(rst), .dv_in(dv4), .data_in(data4), .ovf_clr(clr4),
        .dv_out(dvo4), .src_out(src4), .data_out(dat4),
        .pending_out(pend4), .ovf_out(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat1(input string tag, input logic [31:0] s, input logic [31:0] d);
        check({tag, ".dv"}, 32'(dvo1), 32'd1);
        check({tag, ".src"}, 32'(src1), s);
        check({tag, ".data"}, 32'(dat1), d);
        $display("beat %s: src=%0d data=%05h", tag, src1, dat1);
    endtask

    initial begin
        logic [WD-1:0] exp_d;
        rst   = 1'b1;
        dv1   = '0; data1 = '0; clr1 = 1'b0;
        dv4   = '0; data4 = '0; clr4 = 1'b0;
        tick();
        tick();
        check("reset.dv", 32'(dvo1), 32'd0);
        check("reset.src", 32'(src1), 32'd0);
        check("reset.data", 32'(dat1), 32'd0);
        check("reset.pend", 32'(pend1), 32'd0);
        check("reset.ovf", 32'(ovf1), 32'd0);
        rst = 1'b0;
        tick();

        // All eight sources strobe together; rr_ptr=0 -> 0..7 back to back.
        dv1 = 8'hFF;
        for (int i = 0; i < N; i++) data1[i*WD +: WD] = WD'(i * 18'h01111 + 3);
        tick();
        dv1 = '0;
        check("all.first_idle", 32'(dvo1), 32'd0);
        check("all.pend", 32'(pend1), 32'hFF);
        for (int k = 0; k < N; k++) begin
            tick();
            exp_d = WD'(k * 18'h01111 + 3);
            beat1($sformatf("all%0d", k), 32'(k), 32'(exp_d));
        end
        tick();
        check("all.done_dv", 32'(dvo1), 32'd0);
        check("all.ovf", 32'(ovf1), 32'd0);
        check("all.pend_empty", 32'(pend1), 32'd0);

        // Single source latency: strobe at edge t, beat in cycle t+2.
        dv1 = 8'h08; data1[3*WD +: WD] = 18'h1ABCD;
        tick();
        dv1 = '0;
        check("single.t1_dv", 32'(dvo1), 32'd0);
        check("single.t1_pend3", 32'(pend1[3]), 32'd1);
        tick();
        beat1("single", 32'd3, 32'h1ABCD);
        check("single.pend3_cleared", 32'(pend1[3]), 32'd0);
        tick();
        check("single.after_dv", 32'(dvo1), 32'd0);
        check("single.hold_src", 32'(src1), 32'd3);
        check("single.hold_data", 32'(dat1), 32'h1ABCD);

        // Round robin: grant 5, then 2 and 6 -> 6 before 2; then 7 and 0 wrap.
        dv1 = 8'h20; data1[5*WD +: WD] = 18'h00055;
        tick();
        dv1 = '0;
        tick();
        beat1("rr5", 32'd5, 32'h00055);
        dv1 = 8'h44; data1[2*WD +: WD] = 18'h00022; data1[6*WD +: WD] = 18'h00066;
        tick();
        dv1 = '0;
        tick();
        beat1("rr6", 32'd6, 32'h00066);
        tick();
        beat1("rr2", 32'd2, 32'h00022);
        tick();
        check("rr.idle", 32'(dvo1), 32'd0);
        dv1 = 8'h81; data1[7*WD +: WD] = 18'h00077; data1[0 +: WD] = 18'h3FFFF;
        tick();
        dv1 = '0;
        tick();
        beat1("rr7", 32'd7, 32'h00077);
        tick();
        beat1("rr0_wrap", 32'd0, 32'h3FFFF);

        // Collision: new strobe on the grant cycle of source 2.
        tick();
        dv1 = 8'h04; data1[2*WD +: WD] = 18'h00AAA;
        tick();
        data1[2*WD +: WD] = 18'h00BBB;
        tick();
        dv1 = '0;
        beat1("coll_old", 32'd2, 32'h00AAA);
        check("coll.pend2", 32'(pend1[2]), 32'd1);
        tick();
        beat1("coll_new", 32'd2, 32'h00BBB);
        check("coll.ovf", 32'(ovf1), 32'd0);

        // Overflow on the gap-4 instance.
        dv4 = 8'h01; data4[0 +: WD] = 18'h00007;
        tick();
        dv4 = '0;
        tick();
        check("ovf.src0_dv", 32'(dvo4), 32'd1);
        check("ovf.src0_src", 32'(src4), 32'd0);
        dv4 = 8'h02; data4[1*WD +: WD] = 18'd100;
        tick();
        check("ovf.gap_dv_a", 32'(dvo4), 32'd0);
        data4[1*WD +: WD] = 18'd200;
        tick();
        dv4 = '0;
        check("ovf.flag_set", 32'(ovf4), 32'h02);
        check("ovf.gap_dv_b", 32'(dvo4), 32'd0);
        tick();
        check("ovf.gap_dv_c", 32'(dvo4), 32'd0);
        tick();
        check("ovf.issue_dv", 32'(dvo4), 32'd1);
        check("ovf.issue_src", 32'(src4), 32'd1);
        check("ovf.issue_data", 32'(dat4), 32'd200);
        $display("beat ovf: src=%0d data=%0d ovf=%02h", src4, dat4, ovf4);
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        check("ovf.cleared", 32'(ovf4), 32'h00);
        dv4 = 8'h02; data4[1*WD +: WD] = 18'd300;
        tick();
        data4[1*WD +: WD] = 18'd400;
        clr4 = 1'b1;
        tick();
        dv4 = '0; clr4 = 1'b0;
        check("ovf.clr_vs_event", 32'(ovf4), 32'h02);
        tick();
        check("ovf.second_dv", 32'(dvo4), 32'd1);
        check("ovf.second_data", 32'(dat4), 32'd400);

        // Reset mid-stream with five sources pending.
        dv1 = 8'h1F;
        for (int i = 0; i < 5; i++) data1[i*WD +: WD] = WD'(18'h00100 + i);
        tick();
        dv1 = '0;
        tick();
        check("rst.pre_dv", 32'(dvo1), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst.async_dv", 32'(dvo1), 32'd0);
        check("rst.async_src", 32'(src1), 32'd0);
        check("rst.async_data", 32'(dat1), 32'd0);
        check("rst.async_pend", 32'(pend1), 32'd0);
        check("rst.async_ovf4", 32'(ovf4), 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("rst.quiet%0d", c), 32'(dvo1), 32'd0);
        end
        dv1 = 8'h40; data1[6*WD +: WD] = 18'h20006;
        tick();
        dv1 = '0;
        tick();
        beat1("rst.new", 32'd6, 32'h20006);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
